bf16_add_sched: RTL
===================

# bf16_add_sched

Scheduler that shares one multi-cycle bfloat16 adder among `NREQ` requesters. It round-robin arbitrates operand requests and issues one addition at a time to the adder with a start pulse. It waits for the adder's done pulse, or for a timeout, then returns the sum on a single tagged response channel. It sits between the CNN accumulation lanes and the shared adder instance.

## Interface
- `NREQ`, 4: number of requesters (2..16).
- `TIMEOUT`, 32: cycles allowed in WAIT before the operation is aborted (≥ 8).
- `clk` in 1: the single clock. All state is updated on its rising edge.
- `reset` in 1: **asynchronous, active-low reset**. Low clears all state immediately.
- `req_valid` in NREQ: per-requester operand valid.
- `req_a` in 16*NREQ: operand A. Requester i uses bits [16i+15:16i].
- `req_b` in 16*NREQ: operand B, same packing as `req_a`.
- `req_ready` out NREQ: one-hot grant/accept.
- `rsp_valid` out 1: response valid.
- `rsp_id` out clog2(NREQ): index of the requester that issued the operation.
- `rsp_sum` out 16: bfloat16 result.
- `rsp_err` out 1: set when the operation timed out.
- `rsp_ready` in 1: response consumer ready.
- `add_a`, `add_b` out 16: operands to the adder. Held stable from ISSUE through the end of WAIT.
- `add_go` out 1: one-cycle start pulse to the adder.
- `add_done` in 1: adder result-valid pulse.
- `add_out` in 16: adder result. Sampled only in the cycle where `add_done` is high.

## Operation
- States:
  - IDLE: `req_ready` is combinational. It is one-hot at the first index with `req_valid` high, scanning from `ptr` upward and wrapping modulo NREQ. It is 0 if no `req_valid` is high.
  - A transfer is `req_valid[g] & req_ready[g]`. On a transfer: latch `req_a[g]` and `req_b[g]` into `add_a` and `add_b`, latch `g` into the id register, set `ptr <= (g+1) mod NREQ`, and go to ISSUE.
  - ISSUE: `add_go=1` for exactly this cycle. Clear the timeout counter. Go to WAIT.
  - WAIT: the counter increments each cycle.
    - `add_done=1`: latch `add_out` into `rsp_sum`, set `rsp_err=0`, go to RESP.
    - Otherwise, when the counter reaches `TIMEOUT-1`: set `rsp_sum=16'hFFFF`, set `rsp_err=1`, go to RESP.
    - If `add_done` is high in the same cycle the timeout is reached, the done wins.
  - RESP: `rsp_valid=1`. Hold `rsp_id`, `rsp_sum` and `rsp_err` stable until `rsp_valid & rsp_ready`, then go to IDLE.
- `add_done` is ignored in IDLE, ISSUE and RESP.
- Only one operation is in flight at any time. `req_ready` is 0 in every state except IDLE.
- Requesters must hold `req_valid` and their operands until accepted. The scheduler does not check this.
- `ptr` advances on grant, not on response. A requester that is never valid is skipped with no lost cycles.
- Timeout counter width is clog2(TIMEOUT). It saturates and is never allowed to wrap.

## Timing
- Reset values, with `reset` low:
  - state = IDLE, `ptr` = 0.
  - `add_go`, `rsp_valid` and `rsp_err` are 0.
  - `add_a`, `add_b`, `rsp_sum` and `rsp_id` are 0.
  - `req_ready` is 0 while `reset` is low.
- Reset asserted mid-operation aborts the operation. No response is produced, and the adder result is dropped.
- Accept edge at T: `add_go` high in T+1. The earliest `add_done` that is counted arrives in T+2.
- `add_done` at cycle D: `rsp_valid` is high from D+1.
- With `rsp_ready` held high, the next accept can occur at D+2.
- Minimum occupancy per operation is L+3 cycles, where L is the adder latency from `add_go` to `add_done`.
- Timeout: `rsp_valid` rises TIMEOUT+1 cycles after `add_go`.

## Structure
- Shared package `bf16_pkg` contains:
  - `BF16_W = 16`.
  - `BF16_ERR = 16'hFFFF`, the all-ones NaN pattern the adder also uses.
  - The state enum `sched_state_t` with values IDLE, ISSUE, WAIT, RESP.
- Sub-module `rr_arbiter` (parameter NREQ) contains:
  - Inputs: `req` vector and `ptr`.
  - Outputs: one-hot `gnt` and index `gnt_id`.
  - It is purely combinational and is reused by other shared-resource schedulers.

## Test plan
- Single op: requester 2 sends a=16'h3F80 (1.0) and b=16'h4000 (2.0), with a model adder of L=6.
  - `add_go` is one cycle.
  - Response is `rsp_id=2`, `rsp_sum=16'h4040`, `rsp_err=0`, with `rsp_valid` 8 cycles after accept.
- All four requesters valid continuously: grants occur in order 0,1,2,3,0.
  - Each response id matches its grant.
  - No requester is granted twice before all others are served.
- Backpressure: hold `rsp_ready=0` for 10 cycles during RESP.
  - `rsp_*` stay stable.
  - `req_ready` stays 0.
  - The next accept occurs only after the handshake.
- Timeout: the adder never pulses `add_done`.
  - The response has `rsp_sum=16'hFFFF` and `rsp_err=1`, TIMEOUT+1 cycles after `add_go`.
  - A late `add_done` arriving in RESP or IDLE is ignored.
- Tie at the boundary: `add_done` arrives in the cycle where the counter reaches TIMEOUT-1. Result is the adder's sum with `rsp_err=0`.
- Reset low mid-WAIT:
  - All outputs go to 0 immediately.
  - After release, the first grant goes to the lowest valid index (`ptr=0`).

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared types and constants for the bfloat16 adder scheduler.
// Imported by the interface, the arbiter users and the top.
package bf16_pkg;

  localparam int BF16_W = 16;

  localparam logic [BF16_W-1:0] BF16_ERR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

endpackage

// File: rtl/bf16_add_sched_if.sv
// Request, response and adder-side signals of the shared adder scheduler.
// master is the scheduler side, slave is the environment side.
interface bf16_add_sched_if
  import bf16_pkg::*;
#(
  parameter int NREQ = 4
) ();

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [BF16_W*NREQ-1:0] req_a;
  logic [BF16_W*NREQ-1:0] req_b;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [BF16_W-1:0]      rsp_sum;
  logic                   rsp_err;

  logic [BF16_W-1:0]      add_a;
  logic [BF16_W-1:0]      add_b;
  logic                   add_go;
  logic                   add_done;
  logic [BF16_W-1:0]      add_out;

  modport master (
    input  req_valid,
    input  req_a,
    input  req_b,
    output req_ready,
    output rsp_valid,
    input  rsp_ready,
    output rsp_id,
    output rsp_sum,
    output rsp_err,
    output add_a,
    output add_b,
    output add_go,
    input  add_done,
    input  add_out
  );

  modport slave (
    output req_valid,
    output req_a,
    output req_b,
    input  req_ready,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_id,
    input  rsp_sum,
    input  rsp_err,
    input  add_a,
    input  add_b,
    input  add_go,
    output add_done,
    output add_out
  );

endinterface

// File: rtl/bf16_add_sched_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr,
// wrapping modulo NREQ. Shared with other resource schedulers.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;
  logic           hit;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    hit    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!hit && req[idx]) begin
        hit      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/bf16_add_sched.sv
// Shares one multi-cycle bfloat16 adder among NREQ requesters:
// round-robin accept, start pulse, wait for done or timeout, tagged reply.
module bf16_add_sched
  import bf16_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 32
) (
  input logic              clk,
  input logic              reset,
  bf16_add_sched_if.master bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT);

  localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

  sched_state_t      state_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    ptr_d;
  logic [IDW-1:0]    id_q;
  logic [BF16_W-1:0] a_q;
  logic [BF16_W-1:0] b_q;
  logic [BF16_W-1:0] sum_q;
  logic              err_q;
  logic              go_q;
  logic              vld_q;
  logic [CW-1:0]     cnt_q;

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_id;
  logic [BF16_W-1:0] op_a;
  logic [BF16_W-1:0] op_b;
  logic              xfer;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .gnt   (gnt),
    .gnt_id(gnt_id)
  );

  // Grant only offered in IDLE and never while reset is held.
  assign bus.req_ready = (state_q == IDLE && reset) ? gnt : '0;
  assign xfer = |(bus.req_valid & bus.req_ready);

  assign ptr_d = (gnt_id == LAST) ? '0 : gnt_id + 1'b1;

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        op_a = bus.req_a[BF16_W*i +: BF16_W];
        op_b = bus.req_b[BF16_W*i +: BF16_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      go_q    <= 1'b0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            a_q     <= op_a;
            b_q     <= op_b;
            id_q    <= gnt_id;
            ptr_q   <= ptr_d;
            go_q    <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          go_q    <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q != TMAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
          // A done in the timeout cycle still delivers the real sum.
          if (bus.add_done) begin
            sum_q   <= bus.add_out;
            err_q   <= 1'b0;
            vld_q   <= 1'b1;
            state_q <= RESP;
          end else if (cnt_q == TMAX) begin
            sum_q   <= BF16_ERR;
            err_q   <= 1'b1;
            vld_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            vld_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.add_go    = go_q;
  assign bus.add_a     = a_q;
  assign bus.add_b     = b_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_err   = err_q;

endmodule
